// File: rtl/train_dispatch.sv
// Control-centre dispatcher for the train FSM. It drives ctrl/mng, sequences a trip of
// N_STOPS stops, and checks every evnt code against a cycle-accurate shadow of the train.
module train_dispatch #(
  parameter int unsigned N_STOPS   = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       stop_req,
  input  logic       crew_ok,
  input  logic [3:0] evnt,
  output logic       ctrl,
  output logic       mng,
  output logic       busy,
  output logic [3:0] stop_cnt,
  output logic       done,
  output logic       aborted,
  output logic       door_fault,
  output logic       alarm
);
  localparam logic [3:0] LAST_STOP = 4'(N_STOPS);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {TR_DEPO, TR_TN, TR_ST, TR_OPEN, TR_CLOSE} train_e;
  typedef enum logic [1:0] {DS_IDLE, DS_RUN, DS_ALARM} disp_e;

  train_e     shadow_q, shadow_d;
  disp_e      state_q, state_d;
  logic       ctrl_q, ctrl_d;
  logic       mng_q, mng_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic       door_fault_q, door_fault_d;
  logic       stop_pend_q, stop_pend_d;
  logic [3:0] stop_cnt_q, stop_cnt_d;
  logic [2:0] retry_q, retry_d;
  logic [3:0] evnt_exp;
  logic       mismatch;
  logic       stop_now;

  function automatic train_e train_step(input train_e s, input logic c);
    train_e n;
    unique case (s)
      TR_DEPO:  n = c ? TR_TN   : TR_DEPO;
      TR_TN:    n = c ? TR_ST   : TR_DEPO;
      TR_ST:    n = c ? TR_TN   : TR_OPEN;
      TR_OPEN:  n = c ? TR_TN   : TR_CLOSE;
      TR_CLOSE: n = c ? TR_OPEN : TR_TN;
      default:  n = TR_DEPO;
    endcase
    return n;
  endfunction

  // Event code the train must report for the state/mng pair it currently holds.
  always_comb begin
    unique case (shadow_q)
      TR_DEPO:  evnt_exp = mng_q ? 4'b0000 : 4'b0001;
      TR_TN:    evnt_exp = mng_q ? 4'b0010 : 4'b1000;
      TR_ST:    evnt_exp = 4'b0011;
      TR_OPEN:  evnt_exp = mng_q ? 4'b0100 : 4'b0101;
      TR_CLOSE: evnt_exp = mng_q ? 4'b0110 : 4'b0111;
      default:  evnt_exp = 4'b1111;
    endcase
  end

  assign mismatch = (state_q != DS_ALARM) && (evnt != evnt_exp);
  assign stop_now = stop_pend_q | stop_req;

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    shadow_d     = train_step(shadow_q, ctrl_q);
    mng_d        = crew_ok;
    state_d      = state_q;
    ctrl_d       = 1'b0;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    door_fault_d = door_fault_q;
    stop_pend_d  = stop_pend_q;
    stop_cnt_d   = stop_cnt_q;
    retry_d      = retry_q;

    if (mismatch) begin
      state_d = DS_ALARM;
    end else begin
      unique case (state_q)
        DS_IDLE: begin
          if (go && crew_ok) begin
            state_d      = DS_RUN;
            ctrl_d       = 1'b1;
            stop_cnt_d   = '0;
            retry_d      = '0;
            aborted_d    = 1'b0;
            door_fault_d = 1'b0;
            stop_pend_d  = stop_req;
          end
        end
        DS_RUN: begin
          stop_pend_d = stop_now;
          // ctrl is chosen for the state the train is entering, using next mng = crew_ok.
          unique case (shadow_d)
            TR_TN: begin
              if (!crew_ok) begin
                aborted_d = 1'b1;
              end else if (stop_cnt_q == LAST_STOP || stop_now) begin
                aborted_d = aborted_q | stop_now;
              end else begin
                ctrl_d = 1'b1;
              end
            end
            TR_ST: begin
              stop_cnt_d = stop_cnt_q + 4'd1;
              retry_d    = '0;
            end
            TR_OPEN: begin
              if (!crew_ok) door_fault_d = 1'b1;
            end
            TR_CLOSE: begin
              if (!crew_ok) begin
                door_fault_d = 1'b1;
                if (retry_q < RETRY_MAX) begin
                  ctrl_d  = 1'b1;
                  retry_d = retry_q + 3'd1;
                end else begin
                  state_d = DS_ALARM;
                end
              end
            end
            default: begin
              done_d      = 1'b1;
              state_d     = DS_IDLE;
              stop_pend_d = 1'b0;
            end
          endcase
        end
        default: state_d = DS_ALARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      shadow_q     <= TR_DEPO;
      state_q      <= DS_IDLE;
      ctrl_q       <= 1'b0;
      mng_q        <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      door_fault_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      stop_cnt_q   <= '0;
      retry_q      <= '0;
    end else begin
      shadow_q     <= shadow_d;
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      mng_q        <= mng_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      door_fault_q <= door_fault_d;
      stop_pend_q  <= stop_pend_d;
      stop_cnt_q   <= stop_cnt_d;
      retry_q      <= retry_d;
    end
  end

  assign ctrl       = ctrl_q;
  assign mng        = mng_q;
  assign busy       = (state_q == DS_RUN);
  assign stop_cnt   = stop_cnt_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign door_fault = door_fault_q;
  assign alarm      = (state_q == DS_ALARM);

endmodule

// File: tb/tb_train_dispatch.sv
// Bench for train_dispatch: a train plant answers ctrl/mng with evnt, and a trip-level
// reference model is compared against every DUT output each cycle, plus directed literal checks.
module tb_train_dispatch;
  localparam int N_STOPS   = 4;
  localparam int MAX_RETRY = 2;

  localparam int DEPO = 0, TN = 1, ST = 2, OPEN = 3, CLOSE = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_ALARM = 2;

  logic       clk = 1'b0;
  logic       reset, go, stop_req, crew_ok, force_bad;
  logic [3:0] bad_val;
  logic [3:0] evnt;
  logic       ctrl, mng, busy, done, aborted, door_fault, alarm;
  logic [3:0] stop_cnt;

  int total = 0;
  int bad   = 0;
  bit model_live = 1'b0;
  int zero_left = 0;

  always #5 clk = ~clk;

  train_dispatch #(.N_STOPS(N_STOPS), .MAX_RETRY(MAX_RETRY)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .stop_req   (stop_req),
    .crew_ok    (crew_ok),
    .evnt       (evnt),
    .ctrl       (ctrl),
    .mng        (mng),
    .busy       (busy),
    .stop_cnt   (stop_cnt),
    .done       (done),
    .aborted    (aborted),
    .door_fault (door_fault),
    .alarm      (alarm)
  );

  function automatic int train_next(input int s, input logic c);
    case (s)
      DEPO:    return c ? TN   : DEPO;
      TN:      return c ? ST   : DEPO;
      ST:      return c ? TN   : OPEN;
      OPEN:    return c ? TN   : CLOSE;
      default: return c ? OPEN : TN;
    endcase
  endfunction

  function automatic logic [3:0] ev_of(input int s, input logic m);
    case (s)
      DEPO:    return m ? 4'b0000 : 4'b0001;
      TN:      return m ? 4'b0010 : 4'b1000;
      ST:      return 4'b0011;
      OPEN:    return m ? 4'b0100 : 4'b0101;
      default: return m ? 4'b0110 : 4'b0111;
    endcase
  endfunction

  // Train plant: follows the ctrl actually driven, reset together with the dispatcher.
  int p_st = DEPO;
  always @(posedge clk) p_st <= reset ? DEPO : train_next(p_st, ctrl);
  assign evnt = force_bad ? bad_val : ev_of(p_st, mng);

  // Reference model of the dispatcher, stated as trip rules.
  int   m_train, m_mode, m_stops, m_retry;
  logic m_ctrl, m_mng, m_done, m_abort, m_dfault, m_pend;

  always @(posedge clk) begin : model
    automatic int   nt, mode, stops, retry;
    automatic logic c, dn, ab, df, pend;
    if (reset) begin
      m_train <= DEPO; m_mode <= M_IDLE; m_stops <= 0; m_retry <= 0;
      m_ctrl <= 1'b0; m_mng <= 1'b0; m_done <= 1'b0; m_abort <= 1'b0;
      m_dfault <= 1'b0; m_pend <= 1'b0;
      model_live <= 1'b1;
    end else begin
      nt = train_next(m_train, m_ctrl);
      mode = m_mode; stops = m_stops; retry = m_retry;
      ab = m_abort; df = m_dfault; pend = m_pend; c = 1'b0; dn = 1'b0;
      if (m_mode != M_ALARM && evnt !== ev_of(m_train, m_mng)) begin
        mode = M_ALARM;
      end else if (m_mode == M_IDLE) begin
        if (go && crew_ok) begin
          mode = M_RUN; c = 1'b1; stops = 0; retry = 0; ab = 1'b0; df = 1'b0; pend = stop_req;
        end
      end else if (m_mode == M_RUN) begin
        pend = m_pend | stop_req;
        case (nt)
          TN: begin
            if (!crew_ok) ab = 1'b1;
            else if (stops == N_STOPS || pend) ab = ab | pend;
            else c = 1'b1;
          end
          ST: begin stops = stops + 1; retry = 0; end
          OPEN: if (!crew_ok) df = 1'b1;
          CLOSE: begin
            if (!crew_ok) begin
              df = 1'b1;
              if (retry < MAX_RETRY) begin c = 1'b1; retry = retry + 1; end
              else mode = M_ALARM;
            end
          end
          default: begin dn = 1'b1; mode = M_IDLE; pend = 1'b0; end
        endcase
      end
      m_train <= nt; m_mode <= mode; m_stops <= stops; m_retry <= retry;
      m_ctrl <= c; m_mng <= crew_ok; m_done <= dn; m_abort <= ab;
      m_dfault <= df; m_pend <= pend;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {ctrl, mng, busy, stop_cnt, done, aborted, door_fault, alarm};
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("cycle_outputs", 32'(outs()),
            32'({m_ctrl, m_mng, (m_mode == M_RUN), 4'(m_stops), m_done, m_abort,
                 m_dfault, (m_mode == M_ALARM)}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; go = 1'b0; stop_req = 1'b0; crew_ok = 1'b1; force_bad = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic normal_trip(input string tag);
    int pat[19] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    crew_ok = 1'b1; stop_req = 1'b0; go = 1'b1;
    for (int e = 0; e < 19; e++) begin
      tick();
      go = 1'b0;
      check({tag, "_ctrl"}, 32'(ctrl), 32'(pat[e]));
      check({tag, "_done"}, 32'(done), 32'(e == 18));
    end
    check({tag, "_stop_cnt"}, 32'(stop_cnt), 32'd4);
    check({tag, "_flags"}, 32'({busy, aborted, door_fault, alarm}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; go = 1'b0; stop_req = 1'b0; crew_ok = 1'b1; force_bad = 1'b0; bad_val = '0;
    tick();
    tick();
    check("reset_state", 32'(outs()), 32'd0);
    reset = 1'b0;
    tick();

    // Normal trip: done after edge 18.
    normal_trip("trip_a");
    tick();

    // Single failed close at station 2 reopens the doors; trip ends two edges later.
    go = 1'b1; tick(); go = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      crew_ok = (e != 8);
      tick();
      if (e == 8) begin
        check("retry_ctrl", 32'(ctrl), 32'd1);
        check("retry_door_fault", 32'(door_fault), 32'd1);
      end
      check("retry_done", 32'(done), 32'(e == 20));
    end
    check("retry_stop_cnt", 32'(stop_cnt), 32'd4);
    check("retry_alarm", 32'(alarm), 32'd0);

    // Crew lost from station 1 onward: three failed closes, then alarm.
    crew_ok = 1'b1; go = 1'b1; tick(); go = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      crew_ok = (e < 2);
      tick();
      check("exhaust_alarm", 32'(alarm), 32'(e >= 8));
      check("exhaust_ctrl", 32'(ctrl), 32'(e == 1 || e == 4 || e == 6));
    end
    check("exhaust_door_fault", 32'(door_fault), 32'd1);
    check("exhaust_train_depo", 32'(p_st), 32'(DEPO));
    crew_ok = 1'b1; go = 1'b1; tick(); go = 1'b0;
    check("alarm_go_ignored", 32'({ctrl, busy, alarm}), 32'b001);
    apply_reset();

    // Wrong event while the train sits in ST.
    go = 1'b1; tick(); go = 1'b0; tick(); tick();
    check("mismatch_pre_alarm", 32'(alarm), 32'd0);
    force_bad = 1'b1; bad_val = 4'b1000; tick(); force_bad = 1'b0;
    check("mismatch_alarm", 32'({alarm, ctrl}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mismatch_hold", 32'({alarm, ctrl}), 32'b10);
    end
    apply_reset();

    // stop_req pulsed while at station 1 OPEN.
    go = 1'b1; tick(); go = 1'b0; tick(); tick(); tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    tick();
    check("stop_ctrl", 32'({ctrl, aborted}), 32'b01);
    tick();
    check("stop_done", 32'({done, busy, aborted}), 32'b101);
    check("stop_cnt", 32'(stop_cnt), 32'd1);

    // go together with stop_req: return at the first TN.
    go = 1'b1; stop_req = 1'b1; tick(); go = 1'b0; stop_req = 1'b0;
    tick();
    check("gostop_ctrl", 32'({ctrl, aborted}), 32'b01);
    tick();
    check("gostop_done", 32'(done), 32'd1);
    check("gostop_cnt", 32'(stop_cnt), 32'd0);

    // Reset during station 3 CLOSE, then a fresh normal trip.
    go = 1'b1; tick(); go = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("midtrip_reset", 32'(outs()), 32'd0);
    normal_trip("trip_f");

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      if (zero_left > 0) begin
        crew_ok = 1'b0; zero_left--;
      end else begin
        crew_ok = 1'b1;
        if ($urandom_range(0, 24) == 0) zero_left = $urandom_range(1, 6);
      end
      go        = ($urandom_range(0, 5) == 0);
      stop_req  = ($urandom_range(0, 39) == 0);
      force_bad = ($urandom_range(0, 399) == 0);
      bad_val   = ev_of(p_st, mng) ^ 4'($urandom_range(1, 15));
      reset     = (m_mode == M_ALARM) ? ($urandom_range(0, 15) == 0)
                                      : ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0; go = 1'b0; stop_req = 1'b0; force_bad = 1'b0; crew_ok = 1'b1;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
